// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the FIFO family
package fifo_pkg;

  localparam int FWFT_OFF   = 0;
  localparam int FWFT_ON    = 1;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_DEPTH  = 16;

  // Smallest r with 2**r >= value; usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x DATA_W register file, sync write, async read
module fifo_ram #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock FIFO with status flags and FWFT option
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = FWFT_OFF,
  localparam int ADDR_W   = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wt_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              mem_empty,
  output logic              mem_full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   fill_count,
  output logic              overflow,
  output logic              underflow
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] PTR_WRAP = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

  logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              aempty_q, aempty_d;
  logic              afull_q, afull_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;

  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] ram_rdata;

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  // Acceptance looks only at registered flags, so a full FIFO refuses a write
  // even when a read drains a slot in the same cycle (and vice versa).
  always_comb begin
    wr_acc = wt_en & ~full_q  & ~flush;
    rd_acc = rd_en & ~empty_q & ~flush;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    rd_valid_d = 1'b0;
    data_out_d = data_out_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      wr_ptr_d = wr_ptr_q + CNT_W'(wr_acc);
      rd_ptr_d = rd_ptr_q + CNT_W'(rd_acc);
      count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      ovf_d    = ovf_q | (wt_en & full_q);
      unf_d    = unf_q | (rd_en & empty_q);
      if (FWFT == FWFT_OFF && rd_acc) begin
        rd_valid_d = 1'b1;
        data_out_d = ram_rdata;
      end
    end
  end

  // Flags come from next-state values so they always agree with fill_count.
  always_comb begin
    full_d   = ((wr_ptr_d ^ rd_ptr_d) == PTR_WRAP);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    aempty_d = (count_d <= AEMPTY_C);
    afull_d  = (count_d >= AFULL_C);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      aempty_q   <= 1'b1;
      afull_q    <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      aempty_q   <= aempty_d;
      afull_q    <= afull_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_valid_q <= rd_valid_d;
      data_out_q <= data_out_d;
    end
  end

  // In FWFT mode the head word comes straight off the RAM read port; it is
  // masked while empty so stale RAM contents never leak out after reset.
  always_comb begin
    if (FWFT == FWFT_ON) begin
      data_out = empty_q ? '0 : ram_rdata;
      rd_valid = ~empty_q;
    end else begin
      data_out = data_out_q;
      rd_valid = rd_valid_q;
    end
  end

  assign mem_empty    = empty_q;
  assign mem_full     = full_q;
  assign almost_empty = aempty_q;
  assign almost_full  = afull_q;
  assign fill_count   = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - directed self-checking bench for fifo_sync_param
module tb_fifo_sync_param;

  logic       clk;
  logic       rst;
  logic       flush0, wt_en0, rd_en0;
  logic [3:0] data_in0;
  logic [3:0] data_out0;
  logic       rd_valid0, empty0, full0, aempty0, afull0, ovf0, unf0;
  logic [4:0] count0;

  logic       flush1, wt_en1, rd_en1;
  logic [3:0] data_in1;
  logic [3:0] data_out1;
  logic       rd_valid1, empty1, full1, aempty1, afull1, ovf1, unf1;
  logic [4:0] count1;

  int checks;
  int failures;

  fifo_sync_param #(.DATA_W(4), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush0), .data_in(data_in0), .wt_en(wt_en0), .rd_en(rd_en0),
    .data_out(data_out0), .rd_valid(rd_valid0), .mem_empty(empty0), .mem_full(full0),
    .almost_empty(aempty0), .almost_full(afull0), .fill_count(count0),
    .overflow(ovf0), .underflow(unf0)
  );

  fifo_sync_param #(.DATA_W(4), .DEPTH(16), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .data_in(data_in1), .wt_en(wt_en1), .rd_en(rd_en1),
    .data_out(data_out1), .rd_valid(rd_valid1), .mem_empty(empty1), .mem_full(full1),
    .almost_empty(aempty1), .almost_full(afull1), .fill_count(count1),
    .overflow(ovf1), .underflow(unf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_dout"}, data_out0, 0);
    check({tag, "_rdv"}, rd_valid0, 0);
    check({tag, "_empty"}, empty0, 1);
    check({tag, "_full"}, full0, 0);
    check({tag, "_aempty"}, aempty0, 1);
    check({tag, "_afull"}, afull0, 0);
    check({tag, "_count"}, count0, 0);
    check({tag, "_ovf"}, ovf0, 0);
    check({tag, "_unf"}, unf0, 0);
  endtask

  initial begin
    logic [3:0] exp_w [16];
    checks   = 0;
    failures = 0;
    rst = 1'b0;
    flush0 = 0; wt_en0 = 0; rd_en0 = 0; data_in0 = 0;
    flush1 = 0; wt_en1 = 0; rd_en1 = 0; data_in1 = 0;
    for (int i = 0; i < 16; i++) exp_w[i] = 4'((i * 3) & 15);

    #12;
    check_reset0("rst");
    check("rst_dout1", data_out1, 0);
    check("rst_rdv1", rd_valid1, 0);
    #10 rst = 1'b1;
    tick();

    // 1: fill 0,3,6,... to full; almost_full at 14; overflow on 17th write
    for (int i = 0; i < 16; i++) begin
      wt_en0 = 1; data_in0 = exp_w[i];
      tick();
      check("fill_count", count0, i + 1);
      if (i == 12) check("afull_at13", afull0, 0);
      if (i == 13) check("afull_at14", afull0, 1);
      if (i == 14) check("full_at15", full0, 0);
    end
    check("full_at16", full0, 1);
    check("empty_at16", empty0, 0);
    data_in0 = 4'h9;
    tick();
    wt_en0 = 0;
    check("ovf_set", ovf0, 1);
    check("ovf_count", count0, 16);

    // 2: drain in order, one cycle latency
    for (int i = 0; i < 16; i++) begin
      rd_en0 = 1;
      tick();
      check("drain_data", data_out0, exp_w[i]);
      check("drain_rdv", rd_valid0, 1);
      if (i == 13) check("aempty_at2", aempty0, 1);
      if (i == 12) check("aempty_at3", aempty0, 0);
    end
    check("drain_empty", empty0, 1);
    check("drain_count", count0, 0);
    tick();
    rd_en0 = 0;
    check("unf_set", unf0, 1);
    check("unf_dout_hold", data_out0, 4'hD);
    check("unf_rdv", rd_valid0, 0);
    tick();
    check("rdv_low", rd_valid0, 0);

    // 3: hold count 5 under simultaneous read/write, pointers wrap
    for (int i = 1; i <= 5; i++) begin
      wt_en0 = 1; data_in0 = 4'(i);
      tick();
    end
    check("c5_count", count0, 5);
    rd_en0 = 1;
    for (int k = 0; k < 20; k++) begin
      data_in0 = 4'((k + 6) & 15);
      tick();
      check("rw_count", count0, 5);
      check("rw_data", data_out0, (k + 1) & 15);
    end
    wt_en0 = 0;
    for (int k = 20; k < 25; k++) begin
      tick();
      check("rw_tail", data_out0, (k + 1) & 15);
    end
    rd_en0 = 0;
    tick();
    check("rw_empty", empty0, 1);

    // 4: FWFT head word appears without rd_en
    wt_en1 = 1; data_in1 = 4'hA;
    tick();
    wt_en1 = 0;
    check("fwft_dout", data_out1, 4'hA);
    check("fwft_rdv", rd_valid1, 1);
    tick();
    check("fwft_hold", data_out1, 4'hA);
    rd_en1 = 1;
    tick();
    rd_en1 = 0;
    check("fwft_empty", empty1, 1);
    check("fwft_rdv0", rd_valid1, 0);
    wt_en1 = 1; data_in1 = 4'hB;
    tick();
    data_in1 = 4'hC;
    tick();
    wt_en1 = 0;
    check("fwft_head_b", data_out1, 4'hB);
    rd_en1 = 1;
    tick();
    rd_en1 = 0;
    check("fwft_head_c", data_out1, 4'hC);
    check("fwft_cnt1", count1, 1);

    // 5: flush with a coincident write, overflow still sticky from test 1
    for (int i = 0; i < 8; i++) begin
      wt_en0 = 1; data_in0 = 4'(i);
      tick();
    end
    wt_en0 = 0;
    check("pre_flush_count", count0, 8);
    check("pre_flush_ovf", ovf0, 1);
    flush0 = 1; wt_en0 = 1; data_in0 = 4'hF;
    tick();
    flush0 = 0; wt_en0 = 0;
    check("flush_count", count0, 0);
    check("flush_empty", empty0, 1);
    check("flush_ovf", ovf0, 0);
    check("flush_unf", unf0, 0);
    check("flush_aempty", aempty0, 1);
    tick();
    check("flush_nostore", count0, 0);

    // 6: async reset mid-cycle with 10 entries
    for (int i = 0; i < 10; i++) begin
      wt_en0 = 1; data_in0 = 4'(i + 3);
      tick();
    end
    wt_en0 = 0;
    rd_en0 = 1;
    tick();
    rd_en0 = 0;
    check("pre_rst_count", count0, 9);
    check("pre_rst_dout", data_out0, 3);
    #2 rst = 1'b0;
    #1;
    check_reset0("async_rst");
    #1 rst = 1'b1;
    tick();
    wt_en0 = 1; data_in0 = 4'h7;
    tick();
    wt_en0 = 0; rd_en0 = 1;
    tick();
    rd_en0 = 0;
    check("post_rst_data", data_out0, 4'h7);
    check("post_rst_rdv", rd_valid0, 1);
    check("post_rst_empty", empty0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
